// File: rtl/lsu_fence_ctrl.sv
// Per-warp memory-ordering controller: counts in-flight LSU requests per warp
// and absorbs fences, retiring each only once its warp has drained to zero.
module lsu_fence_ctrl #(
  parameter int NUM_WARPS = 4,
  parameter int CTR_W     = 4,
  localparam int WID_W    = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WID_W-1:0] in_wid,
  input  logic             in_is_fence,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic             cmp_valid,
  input  logic [WID_W-1:0] cmp_wid,
  output logic             fence_done_valid,
  output logic [WID_W-1:0] fence_done_wid,
  input  logic             fence_done_ready,
  output logic             pending_any,
  output logic             underflow_err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t             state;
  logic [WID_W-1:0]   fwid;
  logic [CTR_W-1:0]   cnt [NUM_WARPS];
  logic               blocked;
  logic               issue;
  logic               fence_acc;
  logic [NUM_WARPS-1:0] inc;
  logic [NUM_WARPS-1:0] dec;

  // Non-fence traffic stalls behind its own warp's fence or a saturated counter.
  always_comb begin
    blocked = ((state != S_IDLE) && (in_wid == fwid)) || (cnt[in_wid] == '1);
    if (in_is_fence) begin
      out_valid = 1'b0;
      in_ready  = (state == S_IDLE);
    end else begin
      out_valid = in_valid && !blocked;
      in_ready  = out_ready && !blocked;
    end
    issue     = in_valid && in_ready && !in_is_fence;
    fence_acc = in_valid && in_ready && in_is_fence;
  end

  always_comb begin
    inc         = '0;
    dec         = '0;
    pending_any = 1'b0;
    for (int unsigned w = 0; w < NUM_WARPS; w++) begin
      inc[w]      = issue && (in_wid == WID_W'(w));
      dec[w]      = cmp_valid && (cmp_wid == WID_W'(w));
      pending_any = pending_any || (cnt[w] != '0);
    end
  end

  // Simultaneous issue and completion on one warp cancel; a completion on an
  // empty counter is dropped and flagged instead of wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned w = 0; w < NUM_WARPS; w++) cnt[w] <= '0;
      underflow_err <= 1'b0;
    end else begin
      for (int unsigned w = 0; w < NUM_WARPS; w++) begin
        if (inc[w] && !dec[w]) begin
          cnt[w] <= cnt[w] + CTR_W'(1);
        end else if (dec[w] && !inc[w]) begin
          if (cnt[w] == '0) underflow_err <= 1'b1;
          else              cnt[w] <= cnt[w] - CTR_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      fwid  <= '0;
    end else begin
      case (state)
        S_IDLE: if (fence_acc) begin
          fwid  <= in_wid;
          state <= S_WAIT;
        end
        S_WAIT: if (cnt[fwid] == '0) state <= S_DONE;
        S_DONE: if (fence_done_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign fence_done_valid = (state == S_DONE);
  assign fence_done_wid   = fwid;

endmodule

// File: tb/tb_lsu_fence_ctrl.sv
// Directed bench for lsu_fence_ctrl (4 warps, 2-bit counters) with a
// per-cycle reference model plus hand-computed literal expectations.
module tb_lsu_fence_ctrl;

  localparam int NW   = 4;
  localparam int MAXC = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic [1:0] in_wid = '0;
  logic       in_is_fence = 1'b0;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       cmp_valid = 1'b0;
  logic [1:0] cmp_wid = '0;
  logic       fence_done_valid;
  logic [1:0] fence_done_wid;
  logic       fence_done_ready = 1'b0;
  logic       pending_any;
  logic       underflow_err;

  int errors = 0;
  int checks = 0;

  // Reference model: outstanding count per warp, fence phase 0=none 1=draining 2=retiring
  int mcnt [NW];
  int phase;
  int fw;
  bit merr;

  lsu_fence_ctrl #(.NUM_WARPS(4), .CTR_W(2)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_wid(in_wid), .in_is_fence(in_is_fence), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .cmp_valid(cmp_valid), .cmp_wid(cmp_wid),
    .fence_done_valid(fence_done_valid), .fence_done_wid(fence_done_wid),
    .fence_done_ready(fence_done_ready),
    .pending_any(pending_any), .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int w = 0; w < NW; w++) mcnt[w] = 0;
    phase = 0;
    fw    = 0;
    merr  = 1'b0;
  endtask

  function automatic bit m_blocked();
    return (phase != 0 && int'(in_wid) == fw) || mcnt[in_wid] == MAXC;
  endfunction

  task automatic check_all();
    bit blk = m_blocked();
    bit any = 1'b0;
    for (int w = 0; w < NW; w++) if (mcnt[w] != 0) any = 1'b1;
    chk("out_valid", out_valid, (in_valid && !in_is_fence && !blk) ? 1 : 0);
    chk("in_ready", in_ready, in_is_fence ? (phase == 0 ? 1 : 0) : ((!blk && out_ready) ? 1 : 0));
    chk("done_valid", fence_done_valid, phase == 2 ? 1 : 0);
    chk("done_wid", fence_done_wid, fw);
    chk("pending_any", pending_any, any ? 1 : 0);
    chk("underflow_err", underflow_err, merr ? 1 : 0);
  endtask

  task automatic model_step();
    bit acc_req;
    bit acc_fence;
    if (!reset) begin
      model_clear();
      return;
    end
    acc_req   = in_valid && !in_is_fence && !m_blocked() && out_ready;
    acc_fence = in_valid && in_is_fence && phase == 0;
    case (phase)
      0: if (acc_fence) begin phase = 1; fw = int'(in_wid); end
      1: if (mcnt[fw] == 0) phase = 2;
      default: if (fence_done_ready) phase = 0;
    endcase
    for (int w = 0; w < NW; w++) begin
      int d = ((acc_req && int'(in_wid) == w) ? 1 : 0) - ((cmp_valid && int'(cmp_wid) == w) ? 1 : 0);
      if (d == 1) mcnt[w]++;
      else if (d == -1) begin
        if (mcnt[w] == 0) merr = 1'b1;
        else mcnt[w]--;
      end
    end
  endtask

  // One clock: compare on the falling edge, advance the model on the rising edge.
  task automatic cycle(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_all();
      @(posedge clk);
      model_step();
      #1;
    end
  endtask

  task automatic req(input bit v, input int wid, input bit fence);
    in_valid    = v;
    in_wid      = 2'(wid);
    in_is_fence = fence;
  endtask

  task automatic cmp(input bit v, input int wid);
    cmp_valid = v;
    cmp_wid   = 2'(wid);
  endtask

  initial begin
    model_clear();
    cycle(2);
    out_ready = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_pending", pending_any, 0);
    reset = 1'b1;
    cycle(1);

    // Fence on an idle warp: done two cycles after acceptance, held until ready.
    req(1, 2, 1);
    #1 chk("f2_accept", in_ready, 1);
    cycle(1);
    req(0, 0, 0);
    chk("f2_wait", fence_done_valid, 0);
    cycle(1);
    chk("f2_done", fence_done_valid, 1);
    chk("f2_wid", fence_done_wid, 2);
    cycle(1);
    chk("f2_hold", fence_done_valid, 1);
    fence_done_ready = 1'b1;
    cycle(1);
    fence_done_ready = 1'b0;
    chk("f2_release", fence_done_valid, 0);

    // Fence waits for three outstanding requests on warp 1.
    req(1, 1, 0);
    cycle(3);
    req(1, 1, 1);
    cycle(1);
    req(1, 1, 0);
    #1 chk("w1_blocked_rdy", in_ready, 0);
    chk("w1_blocked_val", out_valid, 0);
    req(1, 0, 0);
    #1 chk("w0_pass_rdy", in_ready, 1);
    chk("w0_pass_val", out_valid, 1);
    cycle(1);
    req(0, 0, 0);
    cmp(1, 1);
    cycle(2);
    chk("w1_not_yet", fence_done_valid, 0);
    cycle(1);
    cmp(0, 0);
    chk("w1_drained_wait", fence_done_valid, 0);
    cycle(1);
    chk("w1_done", fence_done_valid, 1);
    chk("w1_wid", fence_done_wid, 1);
    fence_done_ready = 1'b1;
    cmp(1, 0);
    cycle(1);
    fence_done_ready = 1'b0;
    cmp(0, 0);
    cycle(1);

    // Saturated counter blocks the fourth request until a completion frees a slot.
    req(1, 0, 0);
    cycle(3);
    #1 chk("full_rdy", in_ready, 0);
    chk("full_val", out_valid, 0);
    cmp(1, 0);
    cycle(1);
    cmp(0, 0);
    #1 chk("unfull_rdy", in_ready, 1);
    chk("unfull_val", out_valid, 1);
    req(0, 0, 0);
    cmp(1, 0);
    cycle(2);
    cmp(0, 0);

    // Issue and completion together on warp 3 cancel out.
    req(1, 3, 0);
    cycle(1);
    cmp(1, 3);
    cycle(1);
    req(0, 0, 0);
    chk("w3_same_pend", pending_any, 1);
    cycle(1);
    cmp(0, 0);
    chk("w3_drained", pending_any, 0);

    // Completion on an empty warp sets the sticky error.
    cmp(1, 0);
    cycle(1);
    cmp(0, 0);
    chk("uf_set", underflow_err, 1);
    cycle(2);
    chk("uf_sticky", underflow_err, 1);
    chk("uf_pend", pending_any, 0);

    // Reset mid-fence drops the fence and all counts.
    req(1, 1, 0);
    cycle(2);
    req(1, 1, 1);
    cycle(1);
    req(0, 0, 0);
    cycle(1);
    chk("pre_rst_pend", pending_any, 1);
    reset = 1'b0;
    model_clear();
    #1;
    chk("mid_rst_done", fence_done_valid, 0);
    chk("mid_rst_pend", pending_any, 0);
    chk("mid_rst_uf", underflow_err, 0);
    cycle(2);
    reset = 1'b1;
    cycle(4);
    chk("post_rst_done", fence_done_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
